uart_frame_parser: RTL
======================

# uart_frame_parser

Byte-level frame parser sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and byte, and hunts for a two-byte header. It collects a length-prefixed payload into an internal buffer and checks an 8-bit additive checksum. Only checksum-clean frames are released to the command layer, with a valid pulse and random-access payload reads.

## Interface
- MAX_LEN, 16: maximum payload bytes; buffer depth; legal range 1..255
- HDR0, 8'h55: first header byte
- HDR1, 8'hAA: second header byte
- TIMEOUT_CYC, 24'd600000: inter-byte timeout in clk cycles; used only with FRAME_TIMEOUT_EN
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- din_vld  input  1  byte strobe from UART receiver, one cycle per byte
- din  input  8  received byte, valid when din_vld=1
- frm_vld  output  1  one-cycle pulse: good frame in buffer
- frm_len  output  8  payload length of last good frame
- frm_err  output  1  one-cycle pulse: frame discarded
- err_code  output  2  01 checksum, 10 bad length, 11 timeout; held until next frm_err
- busy  output  1  1 when state is not IDLE
- rd_addr  input  8  payload buffer read address
- rd_data  output  8  buffer[rd_addr], registered

## Operation
- Frame format: HDR0, HDR1, LEN, LEN payload bytes, CHK.
- CHK is (LEN + sum of payload) mod 256, accumulated in an 8-bit register that wraps.
- Bytes are processed only on cycles with din_vld=1. The state machine (3-bit) is as follows:
  - IDLE: din==HDR0 -> S_HDR1; otherwise stay.
  - S_HDR1: din==HDR1 -> S_LEN; din==HDR0 -> stay (resync); otherwise -> IDLE.
  - S_LEN: din==0 or din>MAX_LEN -> frm_err, err_code=10, IDLE. Otherwise len<=din, sum<=din, cnt<=0 -> S_PAY.
  - S_PAY: buf[cnt]<=din, sum<=sum+din, cnt<=cnt+1. When cnt==len-1 -> S_CHK.
  - S_CHK: din==sum -> frm_vld=1, frm_len<=len, IDLE. Otherwise frm_err=1, err_code=01, IDLE.
- Unused encodings 5..7 return to IDLE on the next clk with no output pulse.
- Payload writes of a new frame overwrite the buffer in place. Buffer contents are valid from frm_vld until the next S_PAY write; the consumer reads before the next frame's payload arrives.
- frm_len changes only on frm_vld. A failed frame leaves frm_len unchanged.
- Bytes arriving in IDLE that are not HDR0 are silently dropped; no error is raised.

## Timing
- Reset values: frm_vld=0, frm_err=0, err_code=00, frm_len=0, busy=0, rd_data=0, state=IDLE, cnt=0, sum=0. Buffer memory is not reset.
- frm_vld and frm_err are registered. Each is high for exactly the one cycle after the clk edge that sampled the deciding din_vld.
- frm_vld and frm_err are never high together.
- rd_data = buf[rd_addr] one cycle after rd_addr is presented.
- rd_addr >= MAX_LEN returns 8'h00.
- Reads and writes are independent. A same-cycle read and write to one address returns the old data.
- busy is derived from registered state: it goes high the cycle after HDR0 is accepted and low the cycle frm_vld or frm_err is high.
- din_vld strobes may be back-to-back on consecutive cycles; the parser accepts one byte per clk.
- Reset mid-frame discards the partial frame with no pulse. Parsing restarts in IDLE.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - A 24-bit idle counter clears on every din_vld and increments each cycle while state != IDLE.
  - When it equals TIMEOUT_CYC-1 and din_vld=0, the next edge sets state=IDLE, frm_err=1, err_code=11.
  - frm_err is therefore visible TIMEOUT_CYC cycles after the edge that sampled the last byte.
  - If din_vld coincides with the terminal count, the byte wins: it is processed normally and the counter clears.
  - The counter is held at 0 in IDLE.
- FRAME_TIMEOUT_EN not defined:
  - No counter exists; the parser waits indefinitely mid-frame.
  - err_code=11 is never produced.

## Test plan
- Good frame: 55 AA 03 11 22 33 69 -> frm_vld one cycle after the 69 strobe, frm_len=3, frm_err=0. rd_addr 0,1,2 -> rd_data 11,22,33 one cycle later; rd_addr 3 after the frame -> stale/don't-care, rd_addr 16 -> 00.
- Checksum error: 55 AA 03 11 22 33 68 -> frm_err=1 with err_code=01, no frm_vld, frm_len keeps its previous value, busy=0 afterwards.
- Length errors: 55 AA 00 -> frm_err with err_code=10 right after the 00 strobe. Then 55 AA 11 (17>MAX_LEN) -> err_code=10. Then 55 AA 10, 16 bytes of 01, CHK 20 -> frm_vld, frm_len=16.
- Resync and wrap: 00 55 55 AA 01 FF 00 -> frm_vld, frm_len=1, buf[0]=FF (sum 01+FF wraps to 00). Back-to-back strobes on consecutive cycles give the same result.
- Timeout (macro defined, TIMEOUT_CYC=100): 55 AA 02 11, then silence -> frm_err, err_code=11 exactly 100 cycles after the 11 strobe edge. A byte 22 strobed on cycle 99 instead -> no timeout, the frame continues. Macro undefined: no error after 10000 idle cycles, busy stays 1.
- Reset mid-frame: 55 AA 02 11, rst_n low 2 cycles, then 22 35 -> no frm_vld, no frm_err, all outputs at reset values, busy=0.

Source files
------------

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte strobe in, frame status and payload read port out
interface uart_frame_parser_if;
    logic       din_vld;
    logic [7:0] din;
    logic       frm_vld;
    logic [7:0] frm_len;
    logic       frm_err;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;

    // Upstream receiver plus command-layer consumer.
    modport master (
        output din_vld, din, rd_addr,
        input  frm_vld, frm_len, frm_err, err_code, busy, rd_data
    );

    // The frame parser itself.
    modport slave (
        input  din_vld, din, rd_addr,
        output frm_vld, frm_len, frm_err, err_code, busy, rd_data
    );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - header hunt, length-prefixed payload capture and checksum gate; FRAME_TIMEOUT_EN adds an inter-byte timeout
module uart_frame_parser #(
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  HDR0        = 8'h55,
    parameter logic [7:0]  HDR1        = 8'hAA,
    parameter logic [23:0] TIMEOUT_CYC = 24'd600000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_frame_parser_if.slave pif
);
    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [1:0] ERR_CHK   = 2'b01;
    localparam logic [1:0] ERR_LEN   = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_HDR1 = 3'd1,
        S_LEN  = 3'd2,
        S_PAY  = 3'd3,
        S_CHK  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] frm_len_q, frm_len_d;
    logic       frm_vld_q, frm_vld_d;
    logic       frm_err_q, frm_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       buf_we;
    logic [7:0] buf_mem [0:(1<<AW)-1];

`ifdef FRAME_TIMEOUT_EN
    localparam logic [1:0] ERR_TO = 2'b11;
    logic [23:0] idle_q, idle_d;
    logic        timeout;

    assign timeout = (state_q != IDLE) && !pif.din_vld && (idle_q == TIMEOUT_CYC - 24'd1);

    // Idle counter: cleared by any byte, parked at 0 whenever we are or will be in IDLE.
    always_comb begin
        idle_d = idle_q + 24'd1;
        if (pif.din_vld || state_q == IDLE || state_d == IDLE) begin
            idle_d = 24'd0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 24'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    // Next-state and datapath decode; only bytes with din_vld advance the parse.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        frm_len_d  = frm_len_q;
        frm_vld_d  = 1'b0;
        frm_err_d  = 1'b0;
        err_code_d = err_code_q;
        buf_we     = 1'b0;
        if (state_q > S_CHK) begin
            state_d = IDLE;
        end else if (pif.din_vld) begin
            case (state_q)
                IDLE: begin
                    if (pif.din == HDR0) state_d = S_HDR1;
                end
                S_HDR1: begin
                    if (pif.din == HDR1)      state_d = S_LEN;
                    else if (pif.din == HDR0) state_d = S_HDR1;
                    else                      state_d = IDLE;
                end
                S_LEN: begin
                    if (pif.din == 8'd0 || pif.din > MAX_LEN_B) begin
                        frm_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = IDLE;
                    end else begin
                        len_d   = pif.din;
                        sum_d   = pif.din;
                        cnt_d   = 8'd0;
                        state_d = S_PAY;
                    end
                end
                S_PAY: begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + pif.din;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (pif.din == sum_q) begin
                        frm_vld_d = 1'b1;
                        frm_len_d = len_q;
                    end else begin
                        frm_err_d  = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef FRAME_TIMEOUT_EN
        else if (timeout) begin
            state_d    = IDLE;
            frm_err_d  = 1'b1;
            err_code_d = ERR_TO;
        end
`endif
    end

    // Read port: out-of-range addresses read as zero.
    always_comb begin
        rd_data_d = 8'h00;
        if (pif.rd_addr < MAX_LEN_B) begin
            rd_data_d = buf_mem[pif.rd_addr[AW-1:0]];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= 8'd0;
            sum_q      <= 8'd0;
            cnt_q      <= 8'd0;
            frm_len_q  <= 8'd0;
            frm_vld_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            err_code_q <= 2'b00;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            frm_len_q  <= frm_len_d;
            frm_vld_q  <= frm_vld_d;
            frm_err_q  <= frm_err_d;
            err_code_q <= err_code_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Payload buffer, written in place; not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[cnt_q[AW-1:0]] <= pif.din;
        end
    end

    assign pif.frm_vld  = frm_vld_q;
    assign pif.frm_err  = frm_err_q;
    assign pif.err_code = err_code_q;
    assign pif.frm_len  = frm_len_q;
    assign pif.busy     = (state_q != IDLE);
    assign pif.rd_data  = rd_data_q;
endmodule
